// File: rtl/result_sel_pipe.sv
// N-way operand selector with a registered 2-entry valid/ready skid output stage.
// Out-of-range select codes produce zero data with the error flag raised.
module result_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] opts,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_zero,
  output logic                    out_err
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_zero_q, main_zero_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_zero_q, skid_zero_d;
  logic             skid_err_q, skid_err_d;

  logic [WIDTH-1:0] operand [NUM_IN];
  logic [WIDTH-1:0] sel_data;
  logic             sel_zero;
  logic             sel_err;
  logic             in_fire;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_operand
    assign operand[gi] = opts[gi*WIDTH +: WIDTH];
  end

  // No match for an out-of-range code leaves the data at zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) sel_data = operand[i];
    end
  end

  assign sel_err  = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
  assign sel_zero = (sel_data == '0);

  // Ready depends only on registered state, held low while reset is asserted.
  assign in_ready  = !rst && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_zero_d = main_zero_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_zero_d = skid_zero_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_data_d = sel_data;
          main_zero_d = sel_zero;
          main_err_d  = sel_err;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_ready) begin
          main_data_d = sel_data;
          main_zero_d = sel_zero;
          main_err_d  = sel_err;
        end else if (in_fire) begin
          skid_data_d = sel_data;
          skid_zero_d = sel_zero;
          skid_err_d  = sel_err;
          state_d     = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_data_d = skid_data_q;
          main_zero_d = skid_zero_q;
          main_err_d  = skid_err_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_zero_q <= 1'b1;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_zero_q <= 1'b1;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_zero_q <= main_zero_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_zero_q <= skid_zero_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out      = main_data_q;
  assign out_zero = main_zero_q;
  assign out_err  = main_err_q;

endmodule

// File: tb/tb_result_sel_pipe.sv
// Bench for result_sel_pipe: directed sweep/backpressure/reset on an 8x32 instance,
// range/zero and a randomized scoreboard run on a 12x16 instance.
module tb_result_sel_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, NUM_IN=8
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [255:0] a_opts;
  logic [2:0]   a_sel;
  logic [31:0]  a_out;
  logic         a_out_zero, a_out_err;

  // Instance B: WIDTH=16, NUM_IN=12
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [191:0] b_opts;
  logic [3:0]   b_sel;
  logic [15:0]  b_out;
  logic         b_out_zero, b_out_err;

  result_sel_pipe #(.WIDTH(32), .NUM_IN(8)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .opts(a_opts), .sel(a_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .out_zero(a_out_zero), .out_err(a_out_err)
  );

  result_sel_pipe #(.WIDTH(16), .NUM_IN(12)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .opts(b_opts), .sel(b_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .out_zero(b_out_zero), .out_err(b_out_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference rule: in-range code picks that operand, otherwise zero data with err.
  function automatic logic [17:0] b_expect(input logic [191:0] o, input logic [3:0] s);
    logic [15:0] d;
    logic        e;
    if (s < 12) begin
      d = o[s*16 +: 16];
      e = 1'b0;
    end else begin
      d = '0;
      e = 1'b1;
    end
    return {e, (d == 16'h0), d};
  endfunction

  logic [17:0] exp_q[$];
  logic [17:0] obs, prev_obs, exp_v;
  logic        stall_prev;
  int          n_out, cycles;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_opts = '0; a_sel = '0;
    b_in_valid = 0; b_out_ready = 0; b_opts = '0; b_sel = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out", a_out, 32'h0);
    check("rst_out_zero", a_out_zero, 1'b1);
    check("rst_out_err", a_out_err, 1'b0);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1'b1);

    // Sweep: back-to-back selections, one result per cycle
    for (int i = 0; i < 8; i++) a_opts[i*32 +: 32] = 32'h1000_0000 + i;
    a_out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("sweep_valid", a_out_valid, 1'b1);
        check("sweep_out", a_out, 32'h1000_0000 + i - 1);
        check("sweep_err", a_out_err, 1'b0);
        $display("A sweep xfer sel=%0d out=%h", i - 1, a_out);
      end
      check("sweep_in_ready", a_in_ready, 1'b1);
      a_in_valid = (i < 8);
      a_sel = 3'(i);
      @(negedge clk);
    end
    check("sweep_drained", a_out_valid, 1'b0);

    // Backpressure: two accepts fill the stage, third waits for in_ready
    for (int i = 0; i < 8; i++) a_opts[i*32 +: 32] = 32'(i * 3);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_sel = 3'd2;
    @(negedge clk);
    check("bp_one_ready", a_in_ready, 1'b1);
    check("bp_one_out", a_out, 32'd6);
    a_sel = 3'd5;
    @(negedge clk);
    check("bp_full_ready", a_in_ready, 1'b0);
    check("bp_full_out", a_out, 32'd6);
    a_sel = 3'd7;
    @(negedge clk);
    check("bp_hold_ready", a_in_ready, 1'b0);
    check("bp_hold_out", a_out, 32'd6);
    check("bp_hold_valid", a_out_valid, 1'b1);
    a_out_ready = 1'b1;
    $display("A bp xfer out=%0d", a_out);
    @(negedge clk);
    check("bp_second_out", a_out, 32'd15);
    check("bp_reopen_ready", a_in_ready, 1'b1);
    $display("A bp xfer out=%0d", a_out);
    @(negedge clk);
    check("bp_third_out", a_out, 32'd21);
    check("bp_third_valid", a_out_valid, 1'b1);
    $display("A bp xfer out=%0d", a_out);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", a_out_valid, 1'b0);

    // Async reset while FULL and stalled
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd1;
    @(negedge clk);
    a_sel = 3'd4;
    @(negedge clk);
    check("ar_full", a_in_ready, 1'b0);
    a_in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("ar_out_valid", a_out_valid, 1'b0);
    check("ar_out", a_out, 32'h0);
    check("ar_out_zero", a_out_zero, 1'b1);
    check("ar_out_err", a_out_err, 1'b0);
    check("ar_in_ready", a_in_ready, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ar_post_ready", a_in_ready, 1'b1);
    check("ar_post_valid", a_out_valid, 1'b0);
    a_in_valid = 1'b1; a_sel = 3'd3;
    @(negedge clk);
    check("ar_next_out", a_out, 32'd9);
    check("ar_next_valid", a_out_valid, 1'b1);
    $display("A post-reset xfer out=%0d", a_out);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    check("ar_next_drained", a_out_valid, 1'b0);

    // Zero and range on the 12-input instance
    for (int i = 0; i < 12; i++) b_opts[i*16 +: 16] = 16'h100 + 16'(i);
    b_opts[16 +: 16] = 16'h0;
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_sel = 4'd13;
    @(negedge clk);
    check("rng_out", b_out, 16'h0);
    check("rng_err", b_out_err, 1'b1);
    check("rng_zero", b_out_zero, 1'b1);
    $display("B xfer sel=13 out=%h err=%0b", b_out, b_out_err);
    b_sel = 4'd1;
    @(negedge clk);
    check("zero_out", b_out, 16'h0);
    check("zero_zero", b_out_zero, 1'b1);
    check("zero_err", b_out_err, 1'b0);
    $display("B xfer sel=1 out=%h zero=%0b", b_out, b_out_zero);
    b_sel = 4'd11;
    @(negedge clk);
    check("last_out", b_out, 16'h10B);
    check("last_zero", b_out_zero, 1'b0);
    check("last_err", b_out_err, 1'b0);
    $display("B xfer sel=11 out=%h", b_out);
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_drained", b_out_valid, 1'b0);

    // Randomized run against a depth-2 FIFO scoreboard
    b_out_ready = 1'b0;
    n_out = 0; cycles = 0; stall_prev = 1'b0; prev_obs = '0;
    while (n_out < 10000 && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      obs = {b_out_err, b_out_zero, b_out};
      check("rnd_in_ready", b_in_ready, exp_q.size() < 2);
      check("rnd_out_valid", b_out_valid, exp_q.size() > 0);
      if (stall_prev) check("rnd_stall_hold", obs, prev_obs);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k++) b_opts[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) b_opts[16*$urandom_range(0, 11) +: 16] = 16'h0;
      b_sel = 4'($urandom_range(0, 15));
      if (b_out_valid && b_out_ready && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("rnd_out", obs, exp_v);
        n_out++;
        $display("B rnd xfer %0d out=%h zero=%0b err=%0b", n_out, b_out, b_out_zero, b_out_err);
      end
      if (b_in_valid && b_in_ready) exp_q.push_back(b_expect(b_opts, b_sel));
      stall_prev = b_out_valid && !b_out_ready;
      prev_obs   = obs;
    end
    check("rnd_count", n_out, 10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
